// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Produces a registered word with one-cycle valid/perr/ferr strobes and wrapping frame counters.
module serial_frame_rx #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PARITY_EN = 1,
    parameter int unsigned CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              perr,
    output logic              ferr,
    output logic              busy,
    output logic [CNT_W-1:0]  good_cnt,
    output logic [CNT_W-1:0]  bad_cnt
);

    localparam int unsigned BitCntW = $clog2(DATA_W);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(DATA_W - 1);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2,
        StStop   = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                acc_q, acc_d;
    logic                par_ok_q, par_ok_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                perr_q, perr_d;
    logic                ferr_q, ferr_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    good_q, good_d;
    logic [CNT_W-1:0]    bad_q, bad_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        par_ok_d  = par_ok_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        good_d    = good_q;
        bad_d     = bad_q;

        case (state_q)
            StIdle: begin
                if (!din) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    shreg_d   = '0;
                    acc_d     = 1'b0;
                    // Without a parity bit every frame is parity-clean.
                    par_ok_d  = 1'b1;
                end
            end
            StData: begin
                shreg_d   = {din, shreg_q[DATA_W-1:1]};
                acc_d     = acc_q ^ din;
                bit_cnt_d = bit_cnt_q + BitCntW'(1);
                if (bit_cnt_q == LastBit) begin
                    state_d = (PARITY_EN != 0) ? StParity : StStop;
                end
            end
            StParity: begin
                par_ok_d = ~(acc_q ^ din);
                state_d  = StStop;
            end
            StStop: begin
                state_d = StIdle;
                if (din && par_ok_q) begin
                    data_d  = shreg_q;
                    valid_d = 1'b1;
                    good_d  = good_q + CNT_W'(1);
                end else begin
                    perr_d = ~par_ok_q;
                    ferr_d = ~din;
                    bad_d  = bad_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            acc_q     <= 1'b0;
            par_ok_q  <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            par_ok_q  <= par_ok_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    assign data     = data_q;
    assign valid    = valid_q;
    assign perr     = perr_q;
    assign ferr     = ferr_q;
    assign busy     = busy_q;
    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench for serial_frame_rx: stimulus queues expected strobes, a negedge monitor
// pops and compares them, including the exact cycle each strobe must appear in.
module tb_serial_frame_rx;

    logic       clk;
    logic       reset;
    logic       din;
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       busy;
    logic [7:0] good_cnt;
    logic [7:0] bad_cnt;

    serial_frame_rx #(
        .DATA_W   (8),
        .PARITY_EN(1),
        .CNT_W    (8)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .din     (din),
        .data    (data),
        .valid   (valid),
        .perr    (perr),
        .ferr    (ferr),
        .busy    (busy),
        .good_cnt(good_cnt),
        .bad_cnt (bad_cnt)
    );

    typedef struct {
        int         cyc;
        logic       valid;
        logic       perr;
        logic       ferr;
        logic [7:0] data;
        logic [7:0] good;
        logic [7:0] bad;
    } exp_t;

    exp_t       sb_q[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         cyc     = 0;
    logic [7:0] m_data;
    logic [7:0] m_good;
    logic [7:0] m_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (valid || perr || ferr) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got valid=%0b perr=%0b ferr=%0b expected none",
                         valid, perr, ferr);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("strobe_cycle", cyc, e.cyc);
                chk("valid", {31'd0, valid}, {31'd0, e.valid});
                chk("perr", {31'd0, perr}, {31'd0, e.perr});
                chk("ferr", {31'd0, ferr}, {31'd0, e.ferr});
                chk("data", {24'd0, data}, {24'd0, e.data});
                chk("good_cnt", {24'd0, good_cnt}, {24'd0, e.good});
                chk("bad_cnt", {24'd0, bad_cnt}, {24'd0, e.bad});
            end
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        din = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        exp_t e;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_in_frame", {31'd0, busy}, 32'd1);
            din = d[i];
        end
        drive_bit((^d) ^ par_flip);
        drive_bit(stop);
        e.cyc = cyc + 1;
        if (stop && !par_flip) begin
            m_data  = d;
            m_good  = m_good + 8'd1;
            e.valid = 1'b1;
            e.perr  = 1'b0;
            e.ferr  = 1'b0;
        end else begin
            m_bad   = m_bad + 8'd1;
            e.valid = 1'b0;
            e.perr  = par_flip;
            e.ferr  = ~stop;
        end
        e.data = m_data;
        e.good = m_good;
        e.bad  = m_bad;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        din   = 1'b1;
        repeat (2) @(negedge clk);
        chk("pending_before_reset", sb_q.size(), 32'd0);
        sb_q.delete();
        reset  = 1'b0;
        m_data = 8'h00;
        m_good = 8'h00;
        m_bad  = 8'h00;
        chk("busy_after_reset", {31'd0, busy}, 32'd0);
        chk("good_after_reset", {24'd0, good_cnt}, 32'd0);
    endtask

    initial begin
        reset  = 1'b1;
        din    = 1'b1;
        m_data = 8'h00;
        m_good = 8'h00;
        m_bad  = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_data", {24'd0, data}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_good", {24'd0, good_cnt}, 32'd0);
        chk("rst_bad", {24'd0, bad_cnt}, 32'd0);

        // Idle line
        idle(20);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_good", {24'd0, good_cnt}, 32'd0);
        chk("idle_bad", {24'd0, bad_cnt}, 32'd0);

        // Good frame 0xA5
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(3);
        chk("good_data", {24'd0, data}, 32'hA5);
        chk("good_cnt_after", {24'd0, good_cnt}, 32'd1);
        chk("good_busy_idle", {31'd0, busy}, 32'd0);
        do_reset();

        // Parity error
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(3);
        chk("perr_data_held", {24'd0, data}, 32'h00);
        chk("perr_bad_cnt", {24'd0, bad_cnt}, 32'd1);
        do_reset();

        // Framing error, then a good frame 0x01
        send_frame(8'hA5, 1'b0, 1'b0);
        idle(1);
        send_frame(8'h01, 1'b0, 1'b1);
        idle(3);
        chk("ferr_then_data", {24'd0, data}, 32'h01);
        chk("ferr_then_good", {24'd0, good_cnt}, 32'd1);
        chk("ferr_then_bad", {24'd0, bad_cnt}, 32'd1);
        do_reset();

        // Back-to-back frames, no idle gap
        send_frame(8'hA5, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(3);
        chk("b2b_data", {24'd0, data}, 32'h3C);
        chk("b2b_good", {24'd0, good_cnt}, 32'd2);
        do_reset();

        // Reset mid-frame: start + 4 data bits of 0xA5
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        do_reset();
        send_frame(8'h01, 1'b0, 1'b1);
        idle(3);
        chk("midrst_data", {24'd0, data}, 32'h01);
        chk("midrst_good", {24'd0, good_cnt}, 32'd1);
        chk("midrst_bad", {24'd0, bad_cnt}, 32'd0);
        do_reset();

        // Counter wrap after 256 good frames
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            send_frame(b, 1'b0, 1'b1);
        end
        idle(3);
        chk("wrap_good", {24'd0, good_cnt}, 32'd0);
        chk("wrap_data", {24'd0, data}, 32'hFF);
        chk("wrap_bad", {24'd0, bad_cnt}, 32'd0);

        idle(5);
        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
